// File: rtl/mat_mult_pkg.sv
// Shared types and defaults for the 4x4 matrix-product sequencer and its mat_mult unit.
// Used by every build, including MAT_MULT_CTRL_TRANSPOSE_EN.
package mat_mult_pkg;

    localparam int MAT_DIM = 4;
    localparam int IDX_W   = 4;
    localparam int DEPTH   = MAT_DIM * MAT_DIM;

    localparam int WIDTH_A_DEF      = 9;
    localparam int WIDTH_B_DEF      = 8;
    localparam int WIDTH_SUM_DEF    = 11;
    localparam int MULT_LATENCY_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mat_mult_regfile.sv
// A and B element storage: one write port, combinational A-row and B-column/row reads.
// b_row_mode_i is only driven high in MAT_MULT_CTRL_TRANSPOSE_EN builds.
module mat_mult_regfile
    import mat_mult_pkg::*;
#(
    parameter int WIDTH_A_80 = WIDTH_A_DEF,
    parameter int WIDTH_B_80 = WIDTH_B_DEF
) (
    input  logic                                clk_80,
    input  logic                                rst_80,
    input  logic                                wr_en_i,
    input  logic                                wr_sel_i,
    input  logic [IDX_W-1:0]                    wr_addr_i,
    input  logic [WIDTH_A_80-1:0]               wr_data_i,
    input  logic [1:0]                          row_i,
    input  logic [1:0]                          col_i,
    input  logic                                b_row_mode_i,
    output logic [MAT_DIM-1:0][WIDTH_A_80-1:0]  a_vec_o,
    output logic [MAT_DIM-1:0][WIDTH_B_80-1:0]  b_vec_o
);

    logic [WIDTH_A_80-1:0] mem_a_q [DEPTH];
    logic [WIDTH_B_80-1:0] mem_b_q [DEPTH];

    always_ff @(posedge clk_80 or posedge rst_80) begin
        if (rst_80) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_a_q[k] <= '0;
                mem_b_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            if (!wr_sel_i) begin
                mem_a_q[wr_addr_i] <= wr_data_i;
            end else begin
                mem_b_q[wr_addr_i] <= wr_data_i[WIDTH_B_80-1:0];
            end
        end
    end

    // Transposed mode reads B row col_i instead of B column col_i.
    always_comb begin
        a_vec_o = '0;
        b_vec_o = '0;
        for (int k = 0; k < MAT_DIM; k++) begin
            a_vec_o[k] = mem_a_q[{row_i, k[1:0]}];
            if (b_row_mode_i) begin
                b_vec_o[k] = mem_b_q[{col_i, k[1:0]}];
            end else begin
                b_vec_o[k] = mem_b_q[{k[1:0], col_i}];
            end
        end
    end

endmodule

// File: rtl/mat_mult_ctrl.sv
// Sequences a full 4x4 product C = A x B through one mat_mult row-column unit.
// Defining MAT_MULT_CTRL_TRANSPOSE_EN adds transpose_80, selecting A x B^T per run.
// state | meaning
// IDLE  | accepts element writes and start
// ISSUE | registers A row i and B column j onto the operand outputs
// WAIT  | holds operands for mat_mult, captures its result on the last cycle
// OUT   | presents C[i][j] until res_ready_80
// DONE  | one-cycle completion pulse
module mat_mult_ctrl
    import mat_mult_pkg::*;
#(
    parameter int WIDTH_A_80   = WIDTH_A_DEF,
    parameter int WIDTH_B_80   = WIDTH_B_DEF,
    parameter int WIDTH_SUM    = WIDTH_SUM_DEF,
    parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
    input  logic                  clk_80,
    input  logic                  rst_80,
    input  logic                  wr_en_80,
    input  logic                  wr_sel_80,
    input  logic [IDX_W-1:0]      wr_addr_80,
    input  logic [WIDTH_A_80-1:0] wr_data_80,
    output logic                  wr_err_80,
    input  logic                  start_80,
`ifdef MAT_MULT_CTRL_TRANSPOSE_EN
    input  logic                  transpose_80,
`endif
    output logic                  busy_80,
    output logic                  done_80,
    output logic [WIDTH_A_80-1:0] op_a0_80,
    output logic [WIDTH_A_80-1:0] op_a1_80,
    output logic [WIDTH_A_80-1:0] op_a2_80,
    output logic [WIDTH_A_80-1:0] op_a3_80,
    output logic [WIDTH_B_80-1:0] op_b0_80,
    output logic [WIDTH_B_80-1:0] op_b1_80,
    output logic [WIDTH_B_80-1:0] op_b2_80,
    output logic [WIDTH_B_80-1:0] op_b3_80,
    input  logic [WIDTH_SUM-1:0]  mm_result_80,
    output logic                  res_valid_80,
    input  logic                  res_ready_80,
    output logic [WIDTH_SUM-1:0]  res_data_80,
    output logic [IDX_W-1:0]      res_idx_80
);

    localparam int CNT_W = (MULT_LATENCY < 1) ? 1 : $clog2(MULT_LATENCY + 1);

    state_e                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [CNT_W-1:0]                    wait_q, wait_d;
    logic [MAT_DIM-1:0][WIDTH_A_80-1:0]  op_a_q, op_a_d;
    logic [MAT_DIM-1:0][WIDTH_B_80-1:0]  op_b_q, op_b_d;
    logic [WIDTH_SUM-1:0]                res_data_q, res_data_d;
    logic [IDX_W-1:0]                    res_idx_q, res_idx_d;
    logic                                wr_err_q, wr_err_d;
    logic                                rf_wr_en;
    logic                                b_row_mode;
    logic [MAT_DIM-1:0][WIDTH_A_80-1:0]  a_vec;
    logic [MAT_DIM-1:0][WIDTH_B_80-1:0]  b_vec;

`ifdef MAT_MULT_CTRL_TRANSPOSE_EN
    logic transpose_q, transpose_d;

    always_ff @(posedge clk_80 or posedge rst_80) begin
        if (rst_80) begin
            transpose_q <= 1'b0;
        end else begin
            transpose_q <= transpose_d;
        end
    end

    assign b_row_mode = transpose_q;
`else
    assign b_row_mode = 1'b0;
`endif

    assign rf_wr_en = wr_en_80 && (state_q == IDLE);

    mat_mult_regfile #(
        .WIDTH_A_80 (WIDTH_A_80),
        .WIDTH_B_80 (WIDTH_B_80)
    ) u_regfile (
        .clk_80       (clk_80),
        .rst_80       (rst_80),
        .wr_en_i      (rf_wr_en),
        .wr_sel_i     (wr_sel_80),
        .wr_addr_i    (wr_addr_80),
        .wr_data_i    (wr_data_80),
        .row_i        (idx_q[3:2]),
        .col_i        (idx_q[1:0]),
        .b_row_mode_i (b_row_mode),
        .a_vec_o      (a_vec),
        .b_vec_o      (b_vec)
    );

    always_ff @(posedge clk_80 or posedge rst_80) begin
        if (rst_80) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_data_q <= '0;
            res_idx_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;
        wr_err_d   = wr_en_80 && (state_q != IDLE);
`ifdef MAT_MULT_CTRL_TRANSPOSE_EN
        transpose_d = transpose_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_80) begin
                    idx_d   = '0;
                    state_d = ISSUE;
`ifdef MAT_MULT_CTRL_TRANSPOSE_EN
                    transpose_d = transpose_80;
`endif
                end
            end
            ISSUE: begin
                op_a_d  = a_vec;
                op_b_d  = b_vec;
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == CNT_W'(MULT_LATENCY)) begin
                    res_data_d = mm_result_80;
                    res_idx_d  = idx_q;
                    state_d    = OUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            OUT: begin
                // idx is {i, j}, so a plain increment wraps j and advances i.
                if (res_ready_80) begin
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_80      = (state_q != IDLE);
    assign done_80      = (state_q == DONE);
    assign res_valid_80 = (state_q == OUT);
    assign res_data_80  = res_data_q;
    assign res_idx_80   = res_idx_q;
    assign wr_err_80    = wr_err_q;

    assign op_a0_80 = op_a_q[0];
    assign op_a1_80 = op_a_q[1];
    assign op_a2_80 = op_a_q[2];
    assign op_a3_80 = op_a_q[3];
    assign op_b0_80 = op_b_q[0];
    assign op_b1_80 = op_b_q[1];
    assign op_b2_80 = op_b_q[2];
    assign op_b3_80 = op_b_q[3];

endmodule
